// File: rtl/rk8e_dbrk_pkg.sv
// Shared types for the RK8E data-break channel: FSM state encoding and word-count limit.
package rk8e_dbrk_pkg;

  typedef enum logic [1:0] {
    dbrkIDLE = 2'd0,
    dbrkREQ  = 2'd1,
    dbrkBRK  = 2'd2,
    dbrkGNT  = 2'd3
  } dbrkSTATE_t;

  localparam int DBRK_MAXWORDS = 256;

  // Saturating increment used by the per-sector word counter.
  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'(DBRK_MAXWORDS)) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/rk8e_dbrk_if.sv
// Engine <-> data-break channel bus: one word per request, completed by a dmaGNT pulse.
interface rk8e_dbrk_if;
  logic        dmaREQ;
  logic        dmaRD;
  logic        dmaWR;
  logic [14:0] dmaADDR;
  logic [11:0] dmaDOUT;
  logic [11:0] dmaDIN;
  logic        dmaGNT;

  modport master (output dmaREQ, dmaRD, dmaWR, dmaADDR, dmaDOUT,
                  input  dmaDIN, dmaGNT);
  modport slave  (input  dmaREQ, dmaRD, dmaWR, dmaADDR, dmaDOUT,
                  output dmaDIN, dmaGNT);
endinterface

// File: rtl/rk8e_dbrk.sv
// RK8E data-break (DMA) channel: latches an engine request, runs one CPU break, returns dmaGNT.
// Optional REQ-phase timeout / data-late flag enabled by `RK8E_DBRK_TIMEOUT_EN.
module rk8e_dbrk
  import rk8e_dbrk_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  rk8e_dbrk_if.slave         dma,
  output logic               data_break,
  output logic               to_disk,
  output logic [14:0]        brk_addr,
  output logic [11:0]        brk_dout,
  input  logic               break_in_prog,
  input  logic               brk_done,
  input  logic [11:0]        mem_din,
  input  logic               sec_start,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               dma_late
);

  dbrkSTATE_t        state_q, state_d;
  logic              data_break_q, data_break_d;
  logic              to_disk_q, to_disk_d;
  logic [14:0]       brk_addr_q, brk_addr_d;
  logic [11:0]       brk_dout_q, brk_dout_d;
  logic [11:0]       din_q, din_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  always_comb begin
    state_d      = state_q;
    data_break_d = data_break_q;
    to_disk_d    = to_disk_q;
    brk_addr_d   = brk_addr_q;
    brk_dout_d   = brk_dout_q;
    din_d        = din_q;
    word_cnt_d   = word_cnt_q;

    unique case (state_q)
      dbrkIDLE: begin
        // RD==WR is not a legal request and is simply not accepted.
        if (dma.dmaREQ && (dma.dmaRD ^ dma.dmaWR)) begin
          brk_addr_d   = dma.dmaADDR;
          brk_dout_d   = dma.dmaDOUT;
          to_disk_d    = dma.dmaRD;
          data_break_d = 1'b1;
          state_d      = dbrkREQ;
        end
      end
      dbrkREQ: begin
        // brk_done without break_in_prog implies the break already ran.
        if (brk_done) begin
          data_break_d = 1'b0;
          if (to_disk_q) din_d = mem_din;
          state_d = dbrkGNT;
        end else if (break_in_prog) begin
          data_break_d = 1'b0;
          state_d      = dbrkBRK;
        end
      end
      dbrkBRK: begin
        if (brk_done) begin
          if (to_disk_q) din_d = mem_din;
          state_d = dbrkGNT;
        end
      end
      dbrkGNT: begin
        word_cnt_d = CNT_W'(sat_inc9(9'(word_cnt_q)));
        state_d    = dbrkIDLE;
      end
      default: state_d = dbrkIDLE;
    endcase

    // Sector start clears the count before a same-cycle grant is counted.
    if (sec_start) word_cnt_d = (state_q == dbrkGNT) ? CNT_W'(1) : '0;

    if (clear) begin
      state_d      = dbrkIDLE;
      data_break_d = 1'b0;
      to_disk_d    = 1'b0;
      din_d        = '0;
      word_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= dbrkIDLE;
      data_break_q <= 1'b0;
      to_disk_q    <= 1'b0;
      brk_addr_q   <= '0;
      brk_dout_q   <= '0;
      din_q        <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_break_q <= data_break_d;
      to_disk_q    <= to_disk_d;
      brk_addr_q   <= brk_addr_d;
      brk_dout_q   <= brk_dout_d;
      din_q        <= din_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign data_break = data_break_q;
  assign to_disk    = to_disk_q;
  assign brk_addr   = brk_addr_q;
  assign brk_dout   = brk_dout_q;
  assign word_cnt   = word_cnt_q;
  assign dma.dmaDIN = din_q;
  assign dma.dmaGNT = (state_q == dbrkGNT);

`ifdef RK8E_DBRK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             dma_late_q, dma_late_d;

  // Counts cycles spent waiting for the CPU; data_break stays up regardless.
  always_comb begin
    tmo_d      = '0;
    dma_late_d = dma_late_q;
    if (state_q == dbrkREQ) begin
      tmo_d = (tmo_q == TMO_W'(TIMEOUT_CYC)) ? tmo_q : tmo_q + 1'b1;
      if (tmo_d == TMO_W'(TIMEOUT_CYC)) dma_late_d = 1'b1;
    end
    if (sec_start) dma_late_d = 1'b0;
    if (clear) begin
      tmo_d      = '0;
      dma_late_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q      <= '0;
      dma_late_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      dma_late_q <= dma_late_d;
    end
  end

  assign dma_late = dma_late_q;
`else
  // Timeout disabled: the parameter is kept only for interface compatibility.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
  assign dma_late       = 1'b0;
`endif

endmodule

// File: tb/tb_rk8e_dbrk.sv
// Self-checking bench for rk8e_dbrk; define RK8E_DBRK_TIMEOUT_EN to exercise the timeout with TIMEOUT_CYC=8.
module tb_rk8e_dbrk;
`ifdef RK8E_DBRK_TIMEOUT_EN
  localparam int TMO     = 8;
  localparam bit LATE_EN = 1'b1;
`else
  localparam int TMO     = 255;
  localparam bit LATE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clear, break_in_prog, brk_done, sec_start;
  logic [11:0] mem_din;
  logic        data_break, to_disk, dma_late;
  logic [14:0] brk_addr;
  logic [11:0] brk_dout;
  logic [8:0]  word_cnt;

  rk8e_dbrk_if bus();

  rk8e_dbrk #(.TIMEOUT_CYC(TMO), .CNT_W(9)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .dma           (bus),
    .data_break    (data_break),
    .to_disk       (to_disk),
    .brk_addr      (brk_addr),
    .brk_dout      (brk_dout),
    .break_in_prog (break_in_prog),
    .brk_done      (brk_done),
    .mem_din       (mem_din),
    .sec_start     (sec_start),
    .word_cnt      (word_cnt),
    .dma_late      (dma_late)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int gnt_seen = 0;

  // Reference model state: words per sector, last memory->disk word, data-late flag.
  int          exp_wc   = 0;
  logic [11:0] exp_din  = '0;
  bit          exp_late = 1'b0;

  always @(negedge clk) if (bus.dmaGNT === 1'b1) gnt_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete engine transfer with CPU handshake timing chosen by the caller.
  task automatic do_xfer(input bit rd, input logic [14:0] a, input logic [11:0] d,
                         input logic [11:0] md, input int bip_dly, input bit skip_bip,
                         input int brk_wait, input bit sec_at_gnt);
    bus.dmaREQ  = 1'b1;
    bus.dmaRD   = rd;
    bus.dmaWR   = !rd;
    bus.dmaADDR = a;
    bus.dmaDOUT = d;
    tick();
    chk("dbrk_rise", data_break, 1);
    chk("brk_addr", brk_addr, a);
    chk("brk_dout", brk_dout, d);
    chk("to_disk", to_disk, rd);
    bus.dmaADDR = 15'($urandom);
    bus.dmaDOUT = 12'($urandom);
    for (int i = 1; i <= bip_dly; i++) begin
      tick();
      if (LATE_EN && i >= TMO) exp_late = 1'b1;
      chk("dbrk_hold", data_break, 1);
      chk("late_wait", dma_late, exp_late);
      chk("no_early_gnt", bus.dmaGNT, 0);
    end
    if (!skip_bip) begin
      break_in_prog = 1'b1;
      tick();
      break_in_prog = 1'b0;
      chk("dbrk_fall", data_break, 0);
      for (int i = 0; i < brk_wait; i++) begin
        tick();
        chk("brk_no_gnt", bus.dmaGNT, 0);
      end
    end
    brk_done = 1'b1;
    mem_din  = md;
    tick();
    brk_done = 1'b0;
    mem_din  = 12'($urandom);
    if (rd) exp_din = md;
    chk("gnt_pulse", bus.dmaGNT, 1);
    chk("gnt_din", bus.dmaDIN, exp_din);
    chk("gnt_dbrk", data_break, 0);
    chk("addr_kept", brk_addr, a);
    bus.dmaREQ = 1'b0;
    if (sec_at_gnt) sec_start = 1'b1;
    tick();
    sec_start = 1'b0;
    if (sec_at_gnt) begin
      exp_wc   = 1;
      exp_late = 1'b0;
    end else if (exp_wc < 256) exp_wc++;
    chk("gnt_end", bus.dmaGNT, 0);
    chk("word_cnt", word_cnt, exp_wc);
    chk("late_end", dma_late, exp_late);
    chk("din_hold", bus.dmaDIN, exp_din);
  endtask

  task automatic pulse_sec();
    sec_start = 1'b1;
    tick();
    sec_start = 1'b0;
    exp_wc   = 0;
    exp_late = 1'b0;
    chk("sec_wc", word_cnt, 0);
    chk("sec_late", dma_late, 0);
  endtask

  initial begin
    int g0;
    reset = 1'b1; clear = 1'b0; break_in_prog = 1'b0; brk_done = 1'b0;
    sec_start = 1'b0; mem_din = '0;
    bus.dmaREQ = 1'b0; bus.dmaRD = 1'b0; bus.dmaWR = 1'b0;
    bus.dmaADDR = '0; bus.dmaDOUT = '0;
    #3 reset = 1'b0;
    tick(); tick();
    chk("rst_dbrk", data_break, 0);
    chk("rst_gnt", bus.dmaGNT, 0);
    chk("rst_din", bus.dmaDIN, 0);
    chk("rst_wc", word_cnt, 0);
    chk("rst_late", dma_late, 0);
    chk("rst_addr", brk_addr, 0);
    reset = 1'b1;
    tick();

    // Directed write then read.
    do_xfer(1'b0, 15'o12345, 12'o7070, 12'o0000, 1, 1'b0, 1, 1'b0);
    chk("wr_wc1", word_cnt, 1);
    do_xfer(1'b1, 15'o00200, 12'o0000, 12'o4321, 0, 1'b0, 0, 1'b0);
    chk("rd_din", bus.dmaDIN, 12'o4321);

    // Grant coinciding with sector start counts as the first word.
    do_xfer(1'b0, 15'o00001, 12'o0001, 12'o0000, 0, 1'b1, 0, 1'b1);

    // Burst of 256 writes, then saturation.
    pulse_sec();
    g0 = gnt_seen;
    for (int i = 0; i < 256; i++)
      do_xfer(1'b0, 15'($urandom), 12'($urandom), 12'($urandom), 0, 1'b0, 0, 1'b0);
    chk("burst_gnts", gnt_seen - g0, 256);
    chk("burst_wc", word_cnt, 256);
    do_xfer(1'b0, 15'o07777, 12'o1234, 12'o0000, 0, 1'b0, 0, 1'b0);
    chk("sat_wc", word_cnt, 256);
    pulse_sec();

    // clear during BRK aborts without a grant.
    do_xfer(1'b1, 15'o00010, 12'o0000, 12'o5555, 0, 1'b0, 0, 1'b0);
    bus.dmaREQ = 1'b1; bus.dmaRD = 1'b1; bus.dmaWR = 1'b0; bus.dmaADDR = 15'o00777;
    tick();
    break_in_prog = 1'b1;
    tick();
    break_in_prog = 1'b0;
    g0 = gnt_seen;
    clear = 1'b1; brk_done = 1'b1; mem_din = 12'o6666;
    tick();
    clear = 1'b0; brk_done = 1'b0; bus.dmaREQ = 1'b0;
    exp_wc = 0; exp_din = '0; exp_late = 1'b0;
    chk("clr_dbrk", data_break, 0);
    chk("clr_gnt", bus.dmaGNT, 0);
    chk("clr_todisk", to_disk, 0);
    chk("clr_din", bus.dmaDIN, 0);
    chk("clr_wc", word_cnt, 0);
    tick(); tick();
    chk("clr_no_gnt", gnt_seen - g0, 0);
    do_xfer(1'b1, 15'o01234, 12'o0000, 12'o3210, 2, 1'b0, 1, 1'b0);

    // Long wait for break_in_prog: data-late only when the timeout is built in.
    do_xfer(1'b0, 15'o04000, 12'o0404, 12'o0000, 9, 1'b0, 0, 1'b0);
    chk("late_after", dma_late, LATE_EN);
    pulse_sec();

    // Randomized transfers against the model.
    for (int n = 0; n < 40; n++)
      do_xfer(1'($urandom_range(0, 1)), 15'($urandom), 12'($urandom), 12'($urandom),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0));

    // Illegal request (RD==WR) is ignored.
    bus.dmaREQ = 1'b1; bus.dmaRD = 1'b1; bus.dmaWR = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("illegal_nobrk", data_break, 0);
    end
    bus.dmaREQ = 1'b0;
    tick();

    // Asynchronous reset in the middle of REQ.
    bus.dmaREQ = 1'b1; bus.dmaRD = 1'b0; bus.dmaWR = 1'b1;
    bus.dmaADDR = 15'o17777; bus.dmaDOUT = 12'o7777;
    tick();
    chk("pre_rst_dbrk", data_break, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_dbrk", data_break, 0);
    chk("arst_todisk", to_disk, 0);
    chk("arst_addr", brk_addr, 0);
    chk("arst_dout", brk_dout, 0);
    chk("arst_gnt", bus.dmaGNT, 0);
    chk("arst_din", bus.dmaDIN, 0);
    chk("arst_wc", word_cnt, 0);
    chk("arst_late", dma_late, 0);
    bus.dmaREQ = 1'b0;
    tick();
    reset = 1'b1;
    exp_wc = 0; exp_din = '0; exp_late = 1'b0;
    tick();
    do_xfer(1'b1, 15'o00300, 12'o0000, 12'o1357, 1, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
